// File: rtl/strob_seq_pkg.sv
// Shared types and constants for the strob_seq microcycle strobe sequencer.
package strob_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_G1   = 3'd2,
    ST_MW   = 3'd3,
    ST_G2   = 3'd4,
    ST_S2   = 3'd5,
    ST_GOT  = 3'd6
  } state_e;

  localparam int TICK_W = 8;

  localparam int DEF_S1_TICKS   = 3;
  localparam int DEF_GAP_TICKS  = 2;
  localparam int DEF_S2_TICKS   = 3;
  localparam int DEF_GOT_TICKS  = 2;
  localparam int DEF_WAIT_TICKS = 200;

endpackage

// File: rtl/strob_tick.sv
// Loadable 8-bit down-counter with a zero flag; holds at zero until reloaded.
module strob_tick
  import strob_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [TICK_W-1:0] load_val_i,
  output logic              zero_o
);

  logic [TICK_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TICK_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/strob_seq.sv
// Microcycle strobe sequencer: STROB1, optional memory wait, optional STROB2, then GOT.
// Define STROB_ALARM_EN to add a WAIT_TICKS memory-wait watchdog.
module strob_seq
  import strob_seq_pkg::*;
#(
  parameter int S1_TICKS   = DEF_S1_TICKS,
  parameter int GAP_TICKS  = DEF_GAP_TICKS,
  parameter int S2_TICKS   = DEF_S2_TICKS,
  parameter int GOT_TICKS  = DEF_GOT_TICKS,
  parameter int WAIT_TICKS = DEF_WAIT_TICKS
) (
  input  logic __clk,
  input  logic clo_,
  input  logic pc,
  input  logic es2,
  input  logic emem,
  input  logic ok$,
  input  logic alarm,
  output logic strob1_,
  output logic strob2_,
  output logic got_,
  output logic mem_start,
  output logic nok,
  output logic busy
);

  // Reload value is TICKS-1, with 0 treated as 1 and anything above 256 clamped.
  function automatic logic [TICK_W-1:0] tick_ld(input int t);
    if (t <= 1) begin
      return '0;
    end else if (t >= 256) begin
      return '1;
    end else begin
      return TICK_W'(t - 1);
    end
  endfunction

  localparam logic [TICK_W-1:0] S1_LD   = tick_ld(S1_TICKS);
  localparam logic [TICK_W-1:0] GAP_LD  = tick_ld(GAP_TICKS);
  localparam logic [TICK_W-1:0] S2_LD   = tick_ld(S2_TICKS);
  localparam logic [TICK_W-1:0] GOT_LD  = tick_ld(GOT_TICKS);
  localparam logic [TICK_W-1:0] WAIT_LD = tick_ld(WAIT_TICKS);

  localparam state_e PRE_S2  = (GAP_TICKS > 0) ? ST_G1 : ST_S2;
  localparam state_e POST_S2 = (GAP_TICKS > 0) ? ST_G2 : ST_GOT;

  state_e state_q, state_d;
  logic   pc_q;
  logic   s2_q, s2_d;
  logic   mem_q, mem_d;
  logic   nok_q, nok_d;
  logic   okp_q, okp_d;
  logic   strob1_q, strob2_q, got_q, mem_start_q, busy_q;

  logic              tick_zero;
  logic              tick_load;
  logic [TICK_W-1:0] tick_val;
  logic              wd_alarm;

  always_comb begin
    state_d = state_q;
    s2_d    = s2_q;
    mem_d   = mem_q;
    nok_d   = nok_q;
    okp_d   = okp_q;
    case (state_q)
      ST_IDLE: begin
        if (pc && !pc_q) begin
          state_d = ST_S1;
          s2_d    = es2;
          mem_d   = emem;
          nok_d   = 1'b0;
          okp_d   = 1'b0;
        end
      end
      ST_S1: begin
        // An early answer is remembered so the wait state can finish at once.
        if (ok$) okp_d = 1'b1;
        if (tick_zero) begin
          if (mem_q)     state_d = ST_MW;
          else if (s2_q) state_d = PRE_S2;
          else           state_d = ST_GOT;
        end
      end
      ST_MW: begin
        okp_d = 1'b0;
        if (alarm || wd_alarm) begin
          nok_d   = 1'b1;
          state_d = ST_GOT;
        end else if (okp_q || ok$) begin
          state_d = s2_q ? PRE_S2 : ST_GOT;
        end
      end
      ST_G1:   if (tick_zero) state_d = ST_S2;
      ST_S2:   if (tick_zero) state_d = POST_S2;
      ST_G2:   if (tick_zero) state_d = ST_GOT;
      ST_GOT:  if (tick_zero) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tick_val = '0;
    case (state_d)
      ST_S1:        tick_val = S1_LD;
      ST_G1, ST_G2: tick_val = GAP_LD;
      ST_S2:        tick_val = S2_LD;
      ST_GOT:       tick_val = GOT_LD;
      default:      tick_val = '0;
    endcase
  end

  assign tick_load = (state_d != state_q);

  strob_tick u_phase (
    .clk_i      (__clk),
    .rst_ni     (clo_),
    .load_i     (tick_load),
    .load_val_i (tick_val),
    .zero_o     (tick_zero)
  );

`ifdef STROB_ALARM_EN
  logic wd_zero;

  strob_tick u_wdog (
    .clk_i      (__clk),
    .rst_ni     (clo_),
    .load_i     ((state_d == ST_MW) && (state_q != ST_MW)),
    .load_val_i (WAIT_LD),
    .zero_o     (wd_zero)
  );

  assign wd_alarm = (state_q == ST_MW) && wd_zero;
`else
  // Without the watchdog the wait state only ends on ok$ or the external alarm.
  logic unused_wait;
  assign unused_wait = ^WAIT_LD;
  assign wd_alarm    = 1'b0;
`endif

  always_ff @(posedge __clk or negedge clo_) begin
    if (!clo_) begin
      state_q     <= ST_IDLE;
      pc_q        <= 1'b0;
      s2_q        <= 1'b0;
      mem_q       <= 1'b0;
      nok_q       <= 1'b0;
      okp_q       <= 1'b0;
      strob1_q    <= 1'b1;
      strob2_q    <= 1'b1;
      got_q       <= 1'b1;
      mem_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc;
      s2_q        <= s2_d;
      mem_q       <= mem_d;
      nok_q       <= nok_d;
      okp_q       <= okp_d;
      strob1_q    <= (state_d != ST_S1);
      strob2_q    <= (state_d != ST_S2);
      got_q       <= (state_d != ST_GOT);
      mem_start_q <= (state_d == ST_MW);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign strob1_   = strob1_q;
  assign strob2_   = strob2_q;
  assign got_      = got_q;
  assign mem_start = mem_start_q;
  assign nok       = nok_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_strob_seq.sv
// Randomized scoreboard bench for strob_seq: expected phase lists are queued per
// sequence and a negedge monitor run-length encodes the outputs and compares.
module tb_strob_seq;

  localparam int S1_T  = 3;
  localparam int GAP_T = 2;
  localparam int S2_T  = 3;
  localparam int GOT_T = 2;
  localparam int C_GAP = 0, C_S1 = 1, C_S2 = 2, C_GOT = 3, C_MW = 4, C_END = 7;

  logic clk, clo_, pc, es2, emem, ok, alarm;
  logic strob1_, strob2_, got_, mem_start, nok, busy;

  strob_seq dut (
    .__clk     (clk),
    .clo_      (clo_),
    .pc        (pc),
    .es2       (es2),
    .emem      (emem),
    .ok$       (ok),
    .alarm     (alarm),
    .strob1_   (strob1_),
    .strob2_   (strob2_),
    .got_      (got_),
    .mem_start (mem_start),
    .nok       (nok),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int code;
    int len;
    bit nok;
  } seg_t;

  seg_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  bit   prev_busy = 1'b0;
  int   cur_code = 0;
  int   run_len  = 0;
  int   busy_len = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input int code, input int len, input bit nk);
    seg_t s;
    s.code = code;
    s.len  = len;
    s.nok  = nk;
    exp_q.push_back(s);
  endfunction

  // Phase list for one sequence; mode 0 = ok$ in wait cycle k, 1 = ok$ during
  // STROB1, 2 = alarm together with ok$ in wait cycle k.
  function automatic void build_expected(input bit e2, input bit em, input int mode, input int k);
    int tot;
    int mw;
    bit nk;
    tot = S1_T;
    nk  = 1'b0;
    push(C_S1, S1_T, 1'b0);
    if (em) begin
      mw = (mode == 1) ? 1 : k;
      push(C_MW, mw, 1'b0);
      tot += mw;
      if (mode == 2) nk = 1'b1;
    end
    if (!nk && e2) begin
      push(C_GAP, GAP_T, 1'b0);
      push(C_S2, S2_T, 1'b0);
      push(C_GAP, GAP_T, 1'b0);
      tot += 2 * GAP_T + S2_T;
    end
    push(C_GOT, GOT_T, 1'b0);
    tot += GOT_T;
    push(C_END, tot, nk);
  endfunction

  function automatic int code_of();
    if (!strob1_)  return C_S1;
    if (!strob2_)  return C_S2;
    if (!got_)     return C_GOT;
    if (mem_start) return C_MW;
    return C_GAP;
  endfunction

  task automatic seg_done();
    seg_t e;
    if (exp_q.size() == 0 || exp_q[0].code == C_END) begin
      checks++;
      failures++;
      $display("FAIL seg_extra: got code %0d len %0d, expected no segment", cur_code, run_len);
    end else begin
      e = exp_q.pop_front();
      check("seg_code", cur_code, e.code);
      check("seg_len", run_len, e.len);
    end
    run_len = 0;
  endtask

  task automatic end_done();
    seg_t e;
    while (exp_q.size() > 0 && exp_q[0].code != C_END) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL seg_missing: got none, expected code %0d len %0d", e.code, e.len);
    end
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL seq_end: got end of busy, expected no sequence");
    end else begin
      e = exp_q.pop_front();
      check("busy_len", busy_len, e.len);
      check("nok_end", int'(nok), int'(e.nok));
    end
    busy_len = 0;
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_busy = 1'b0;
      run_len   = 0;
      busy_len  = 0;
    end else begin
      check("exclusive", int'($countones({~strob1_, ~strob2_, ~got_}) <= 1), 1);
      if (busy) begin
        if (run_len > 0 && code_of() != cur_code) seg_done();
        cur_code = code_of();
        run_len++;
        busy_len++;
      end else begin
        check("idle_quiet", int'({strob1_, strob2_, got_, mem_start}), 4'b1110);
        if (prev_busy) begin
          seg_done();
          end_done();
        end
      end
      prev_busy = busy;
    end
  end

  // Called #1 after a rising edge with the DUT idle.
  task automatic run_seq(input bit e2, input bit em, input int mode, input int k, input int plen);
    bit done;
    done = 1'b0;
    build_expected(e2, em, mode, k);
    pc   = 1'b1;
    es2  = e2;
    emem = em;
    for (int c = 1; c <= 400 && !done; c++) begin
      @(posedge clk);
      #1;
      ok    = 1'b0;
      alarm = 1'b0;
      if (c == 1) begin
        check("nok_clear", int'(nok), 0);
        es2  = 1'($urandom);
        emem = 1'($urandom);
      end
      if (c >= plen) pc = 1'b0;
      if (mode == 1 && c == 2) ok = 1'b1;
      if (mode != 1 && c == 3 + k) begin
        ok    = 1'b1;
        alarm = (mode == 2);
      end
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL seq_timeout: got busy after 400 cycles, expected idle");
    end
    pc    = 1'b0;
    ok    = 1'b0;
    alarm = 1'b0;
  endtask

  initial begin
    clo_  = 1'b0;
    pc    = 1'b0;
    es2   = 1'b0;
    emem  = 1'b0;
    ok    = 1'b0;
    alarm = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strob1", int'(strob1_), 1);
    check("rst_strob2", int'(strob2_), 1);
    check("rst_got", int'(got_), 1);
    check("rst_mem_start", int'(mem_start), 0);
    check("rst_nok", int'(nok), 0);
    check("rst_busy", int'(busy), 0);
    clo_ = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    run_seq(1'b0, 1'b0, 0, 1, 1);
    run_seq(1'b1, 1'b0, 0, 1, 2);
    run_seq(1'b1, 1'b1, 0, 7, 1);
    run_seq(1'b1, 1'b1, 1, 0, 3);
    run_seq(1'b1, 1'b1, 2, 4, 1);
    run_seq(1'b0, 1'b0, 0, 1, 1);
    run_seq(1'b0, 1'b1, 0, 3, 2);
    run_seq(1'b0, 1'b1, 2, 1, 1);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_seq(1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
              int'($urandom_range(1, 12)), int'($urandom_range(1, 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Second pc edge during STROB2, then reset mid-STROB2.
    @(posedge clk);
    #1;
    pc   = 1'b1;
    es2  = 1'b1;
    emem = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        pc = 1'b0;
        check("abort_s1_low", int'(strob1_), 0);
      end
      if (c == 6) begin
        pc = 1'b1;
        check("abort_s2_low", int'(strob2_), 0);
      end
      if (c == 7) begin
        check("edge_ignored_s1", int'(strob1_), 1);
        check("edge_ignored_s2", int'(strob2_), 0);
      end
    end
    #2;
    clo_ = 1'b0;
    #1;
    check("abort_strob1", int'(strob1_), 1);
    check("abort_strob2", int'(strob2_), 1);
    check("abort_got", int'(got_), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_mem_start", int'(mem_start), 0);
    pc = 1'b0;
    @(posedge clk);
    #1;
    clo_ = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      check("no_got_after_abort", int'(got_), 1);
      check("idle_after_abort", int'(busy), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
